// File: rtl/fir_seq_ctrl.sv
// Sequencer for an 11-tap FIR engine: takes samples from an AXI-Stream slave,
// keeps them in a ring buffer in the data BRAM, runs one MAC pass per sample
// against the tap BRAM and sends each result out on an AXI-Stream master.
// Ports:
//   axis_clk, axis_rst_n        clock, async active-low reset
//   ap_start, data_length       start pulse and sample count (latched on start)
//   ap_idle, ap_done            status (ap_done sticky until next start)
//   ss_*                        input stream (ss_tlast ignored)
//   sm_*                        output stream
//   tap_EN/tap_A/tap_Do         tap BRAM read port (1-cycle latency)
//   data_EN/WE/A/Di/Do          data BRAM port (1-cycle read latency)
module fir_seq_ctrl #(
   parameter int unsigned NUM_TAP = 11,
   parameter int unsigned DW      = 32,
   parameter int unsigned AW      = 12
) (
   input  logic          axis_clk,
   input  logic          axis_rst_n,
   input  logic          ap_start,
   input  logic [31:0]   data_length,
   output logic          ap_idle,
   output logic          ap_done,
   input  logic          ss_tvalid,
   input  logic [DW-1:0] ss_tdata,
   input  logic          ss_tlast,
   output logic          ss_tready,
   output logic          sm_tvalid,
   output logic [DW-1:0] sm_tdata,
   output logic          sm_tlast,
   input  logic          sm_tready,
   output logic          tap_EN,
   output logic [AW-1:0] tap_A,
   input  logic [DW-1:0] tap_Do,
   output logic          data_EN,
   output logic [3:0]    data_WE,
   output logic [AW-1:0] data_A,
   output logic [DW-1:0] data_Di,
   input  logic [DW-1:0] data_Do
);

   localparam int unsigned CW = $clog2(NUM_TAP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] clr_q, clr_d;
   logic [CW-1:0] k_q, k_d;
   logic [CW-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0] head_q, head_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   len_q, len_d;
   logic [DW-1:0] acc_q, acc_d;
   logic          rd_vld_q, rd_vld_d;
   logic          ap_idle_q, ap_idle_d;
   logic          ap_done_q, ap_done_d;
   logic          ss_tready_q, ss_tready_d;
   logic          sm_tvalid_q, sm_tvalid_d;
   logic [DW-1:0] sm_tdata_q, sm_tdata_d;
   logic          sm_tlast_q, sm_tlast_d;
   logic          tap_en_q, tap_en_d;
   logic [AW-1:0] tap_a_q, tap_a_d;
   logic          data_en_q, data_en_d;
   logic [3:0]    data_we_q, data_we_d;
   logic [AW-1:0] data_a_q, data_a_d;

   logic [DW-1:0] prod_c;
   logic [CW-1:0] head_inc_c;
   logic [CW-1:0] rd_idx_dec_c;
   logic          ss_hs_c;
   logic          unused_ss_tlast;

   function automatic logic [AW-1:0] word_addr(input logic [CW-1:0] idx);
      return AW'({idx, 2'b00});
   endfunction

   // Low DW bits of a product are identical for signed and unsigned operands.
   assign prod_c       = tap_Do * data_Do;
   assign head_inc_c   = (head_q == CW'(NUM_TAP - 1)) ? '0 : head_q + CW'(1);
   assign rd_idx_dec_c = (rd_idx_q == '0) ? CW'(NUM_TAP - 1) : rd_idx_q - CW'(1);
   assign ss_hs_c      = ss_tvalid & ss_tready_q;
   assign unused_ss_tlast = ss_tlast;

   // State and datapath registers
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= S_IDLE;
         clr_q       <= '0;
         k_q         <= '0;
         rd_idx_q    <= '0;
         head_q      <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         acc_q       <= '0;
         rd_vld_q    <= 1'b0;
         ap_idle_q   <= 1'b1;
         ap_done_q   <= 1'b0;
         ss_tready_q <= 1'b0;
         sm_tvalid_q <= 1'b0;
         sm_tdata_q  <= '0;
         sm_tlast_q  <= 1'b0;
         tap_en_q    <= 1'b0;
         tap_a_q     <= '0;
         data_en_q   <= 1'b0;
         data_we_q   <= '0;
         data_a_q    <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         k_q         <= k_d;
         rd_idx_q    <= rd_idx_d;
         head_q      <= head_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         rd_vld_q    <= rd_vld_d;
         ap_idle_q   <= ap_idle_d;
         ap_done_q   <= ap_done_d;
         ss_tready_q <= ss_tready_d;
         sm_tvalid_q <= sm_tvalid_d;
         sm_tdata_q  <= sm_tdata_d;
         sm_tlast_q  <= sm_tlast_d;
         tap_en_q    <= tap_en_d;
         tap_a_q     <= tap_a_d;
         data_en_q   <= data_en_d;
         data_we_q   <= data_we_d;
         data_a_q    <= data_a_d;
      end
   end

   // Next state; registered outputs are computed for the state being entered
   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      k_d         = k_q;
      rd_idx_d    = rd_idx_q;
      head_d      = head_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      acc_d       = acc_q;
      rd_vld_d    = 1'b0;
      ap_done_d   = ap_done_q;
      ss_tready_d = ss_tready_q;
      sm_tvalid_d = sm_tvalid_q;
      sm_tdata_d  = sm_tdata_q;
      sm_tlast_d  = sm_tlast_q;
      tap_en_d    = tap_en_q;
      tap_a_d     = tap_a_q;
      data_en_d   = data_en_q;
      data_we_d   = data_we_q;
      data_a_d    = data_a_q;

      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               state_d   = S_CLEAR;
               len_d     = data_length;
               ap_done_d = 1'b0;
               cnt_d     = '0;
               head_d    = '0;
               clr_d     = '0;
               data_en_d = 1'b1;
               data_we_d = 4'hF;
               data_a_d  = word_addr('0);
            end
         end
         S_CLEAR: begin
            if (clr_q == CW'(NUM_TAP - 1)) begin
               data_we_d = '0;
               if (len_q == '0) begin
                  state_d   = S_DONE;
                  ap_done_d = 1'b1;
                  data_en_d = 1'b0;
                  data_a_d  = '0;
               end else begin
                  state_d     = S_WAIT_IN;
                  ss_tready_d = 1'b1;
                  data_a_d    = word_addr(head_q);
               end
            end else begin
               clr_d    = clr_q + CW'(1);
               data_a_d = word_addr(clr_q + CW'(1));
            end
         end
         S_WAIT_IN: begin
            // The write itself happens this cycle through data_WE/data_Di.
            if (ss_tvalid) begin
               state_d     = S_MAC;
               ss_tready_d = 1'b0;
               k_d         = '0;
               rd_idx_d    = head_q;
               acc_d       = '0;
               tap_en_d    = 1'b1;
               tap_a_d     = word_addr('0);
               data_a_d    = word_addr(head_q);
            end
         end
         S_MAC: begin
            rd_vld_d = (k_q < CW'(NUM_TAP));
            if (rd_vld_q) begin
               acc_d = acc_q + prod_c;
            end
            if (k_q < CW'(NUM_TAP - 1)) begin
               k_d      = k_q + CW'(1);
               rd_idx_d = rd_idx_dec_c;
               tap_a_d  = word_addr(k_q + CW'(1));
               data_a_d = word_addr(rd_idx_dec_c);
            end else if (k_q == CW'(NUM_TAP - 1)) begin
               k_d       = CW'(NUM_TAP);
               tap_en_d  = 1'b0;
               tap_a_d   = '0;
               data_en_d = 1'b0;
               data_a_d  = '0;
            end else begin
               state_d     = S_OUT;
               sm_tvalid_d = 1'b1;
               sm_tdata_d  = acc_d;
               sm_tlast_d  = ((cnt_q + 32'd1) == len_q);
            end
         end
         S_OUT: begin
            if (sm_tready) begin
               sm_tvalid_d = 1'b0;
               sm_tlast_d  = 1'b0;
               head_d      = head_inc_c;
               cnt_d       = cnt_q + 32'd1;
               if ((cnt_q + 32'd1) == len_q) begin
                  state_d   = S_DONE;
                  ap_done_d = 1'b1;
               end else begin
                  state_d     = S_WAIT_IN;
                  ss_tready_d = 1'b1;
                  data_en_d   = 1'b1;
                  data_a_d    = word_addr(head_inc_c);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ap_idle_d = (state_d == S_IDLE);
   end

   assign ap_idle   = ap_idle_q;
   assign ap_done   = ap_done_q;
   assign ss_tready = ss_tready_q;
   assign sm_tvalid = sm_tvalid_q;
   assign sm_tdata  = sm_tdata_q;
   assign sm_tlast  = sm_tlast_q;
   assign tap_EN    = tap_en_q;
   assign tap_A     = tap_a_q;
   assign data_EN   = data_en_q;
   assign data_A    = data_a_q;
   // Sample write lands in the handshake cycle so the first MAC read sees it.
   assign data_WE   = data_we_q | {4{ss_hs_c}};
   assign data_Di   = ss_tready_q ? ss_tdata : '0;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;
   localparam int unsigned NUM_TAP = 11;
   localparam int unsigned DW      = 32;
   localparam int unsigned AW      = 12;

   logic          axis_clk = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic          ap_start = 1'b0;
   logic [31:0]   data_length = '0;
   logic          ap_idle, ap_done;
   logic          ss_tvalid = 1'b0;
   logic [DW-1:0] ss_tdata = '0;
   logic          ss_tlast = 1'b0;
   logic          ss_tready;
   logic          sm_tvalid;
   logic [DW-1:0] sm_tdata;
   logic          sm_tlast;
   logic          sm_tready = 1'b1;
   logic          tap_EN;
   logic [AW-1:0] tap_A;
   logic [DW-1:0] tap_Do;
   logic          data_EN;
   logic [3:0]    data_WE;
   logic [AW-1:0] data_A;
   logic [DW-1:0] data_Di;
   logic [DW-1:0] data_Do;

   fir_seq_ctrl #(.NUM_TAP(NUM_TAP), .DW(DW), .AW(AW)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
      .ap_start(ap_start), .data_length(data_length),
      .ap_idle(ap_idle), .ap_done(ap_done),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
      .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
      .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
   );

   always #5 axis_clk = ~axis_clk;

   int n_cmp = 0;
   int n_err = 0;
   int taps [NUM_TAP] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
   int hand [4] = '{0, -10, -29, -25};
   logic [DW-1:0] tap_mem  [0:15];
   logic [DW-1:0] data_mem [0:15];
   time hs_t, prev_t;

   // Synchronous-read BRAM models
   always @(posedge axis_clk) begin
      if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
      if (data_EN) begin
         if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
         data_Do <= data_mem[data_A[5:2]];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs,
                $signed(exp), exp);
      end
   endtask

   // Direct convolution of x[i]=i+1 with the tap set, 32-bit wrap
   function automatic logic [31:0] fir_ref(input int n);
      int s;
      s = 0;
      for (int k = 0; k < int'(NUM_TAP); k++)
         if (n - k >= 0) s += taps[k] * (n - k + 1);
      return 32'(s);
   endfunction

   task automatic start_run(input int len);
      data_length = 32'(len);
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      chk("start_done_clr", 32'(ap_done), 32'd0);
      chk("start_idle_low", 32'(ap_idle), 32'd0);
      chk("start_clear_we", 32'(data_WE), 32'hF);
   endtask

   task automatic do_sample(input int n, input int len, input int gap, input int stall,
                            input bit poke, input bit tp);
      bit ok;
      int lat;
      logic [DW-1:0] held, exp;
      exp = fir_ref(n);
      sm_tready = (stall == 0);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (ss_tready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk($sformatf("ss_tready_wait[%0d]", n), 32'(ok), 32'd1);
      for (int i = 0; i < gap; i++) step();
      if (gap > 0) chk($sformatf("ss_tready_gap[%0d]", n), 32'(ss_tready), 32'd1);
      ss_tvalid = 1'b1;
      ss_tdata  = DW'(n + 1);
      ap_start  = poke;
      hs_t = $time;
      if (tp && n > 0) chk($sformatf("throughput[%0d]", n), 32'(hs_t - prev_t), 32'd140);
      prev_t = hs_t;
      step();
      ss_tvalid = 1'b0;
      ss_tdata  = '0;
      ap_start  = 1'b0;
      chk($sformatf("ss_tready_mac[%0d]", n), 32'(ss_tready), 32'd0);
      lat = 1;
      ok = 1'b0;
      while (lat < 40) begin
         if (sm_tvalid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         ap_start = poke && (lat == 4);
         step();
         ap_start = 1'b0;
         lat++;
      end
      chk($sformatf("sm_tvalid_wait[%0d]", n), 32'(ok), 32'd1);
      chk($sformatf("latency[%0d]", n), 32'(lat), 32'd13);
      held = sm_tdata;
      for (int i = 0; i < stall; i++) begin
         step();
         chk($sformatf("stall_valid[%0d]", n), 32'(sm_tvalid), 32'd1);
         chk($sformatf("stall_data[%0d]", n), sm_tdata, held);
      end
      sm_tready = 1'b1;
      chk($sformatf("y[%0d]", n), sm_tdata, exp);
      if (n < 4) chk($sformatf("y_hand[%0d]", n), sm_tdata, 32'(hand[n]));
      if (n == 63) chk("y_hand[63]", sm_tdata, 32'd10797);
      chk($sformatf("tlast[%0d]", n), 32'(sm_tlast), 32'(n == len - 1));
      step();
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_done_set"}, 32'(ap_done), 32'd1);
      chk({tag, "_idle_still_low"}, 32'(ap_idle), 32'd0);
      step();
      chk({tag, "_idle_set"}, 32'(ap_idle), 32'd1);
      chk({tag, "_done_sticky"}, 32'(ap_done), 32'd1);
      chk({tag, "_ss_tready_off"}, 32'(ss_tready), 32'd0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_ap_idle"}, 32'(ap_idle), 32'd1);
      chk({tag, "_ap_done"}, 32'(ap_done), 32'd0);
      chk({tag, "_ss_tready"}, 32'(ss_tready), 32'd0);
      chk({tag, "_sm_tvalid"}, 32'(sm_tvalid), 32'd0);
      chk({tag, "_sm_tdata"}, sm_tdata, 32'd0);
      chk({tag, "_sm_tlast"}, 32'(sm_tlast), 32'd0);
      chk({tag, "_tap_EN"}, 32'(tap_EN), 32'd0);
      chk({tag, "_tap_A"}, 32'(tap_A), 32'd0);
      chk({tag, "_data_EN"}, 32'(data_EN), 32'd0);
      chk({tag, "_data_WE"}, 32'(data_WE), 32'd0);
      chk({tag, "_data_A"}, 32'(data_A), 32'd0);
      chk({tag, "_data_Di"}, data_Di, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) tap_mem[i] = (i < int'(NUM_TAP)) ? DW'(taps[i]) : '0;
      #12;
      chk_reset_values("rst");
      axis_rst_n = 1'b1;
      step();
      chk_reset_values("post_rst");

      // Run A: golden, full rate, CLEAR timing checked cycle by cycle
      start_run(64);
      chk("clear_addr_first", 32'(data_A), 32'd0);
      chk("clear_di_zero", data_Di, 32'd0);
      for (int i = 0; i < 10; i++) step();
      chk("clear_addr_last", 32'(data_A), 32'd40);
      chk("clear_we_last", 32'(data_WE), 32'hF);
      chk("clear_no_tready", 32'(ss_tready), 32'd0);
      step();
      chk("tready_cycle12", 32'(ss_tready), 32'd1);
      chk("we_off_cycle12", 32'(data_WE), 32'd0);
      for (int n = 0; n < 64; n++) do_sample(n, 64, 0, 0, 1'b0, 1'b1);
      end_checks("runA");

      // Run B: back-to-back, with input gaps, back-pressure and stray ap_start pulses
      start_run(64);
      for (int n = 0; n < 64; n++)
         do_sample(n, 64, n % 3, (n % 4 == 1) ? 3 : ((n % 5 == 2) ? 1 : 0),
                   (n % 16) == 7, 1'b0);
      end_checks("runB");

      // Zero-length run
      start_run(0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("len0_no_tready", 32'(ss_tready), 32'd0);
      end
      step();
      chk("len0_done_cycle12", 32'(ap_done), 32'd1);
      chk("len0_no_tready12", 32'(ss_tready), 32'd0);
      step();
      chk("len0_idle", 32'(ap_idle), 32'd1);

      // Reset while in MAC
      start_run(64);
      for (int i = 0; i < 11; i++) step();
      ss_tvalid = 1'b1;
      ss_tdata  = 32'd99;
      step();
      ss_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mac_tap_en", 32'(tap_EN), 32'd1);
      #2 axis_rst_n = 1'b0;
      #1;
      chk_reset_values("mid_rst");
      step();
      axis_rst_n = 1'b1;
      step();

      // Run C: short run after reset, wraps the ring buffer once
      start_run(12);
      for (int n = 0; n < 12; n++) do_sample(n, 12, (n == 5) ? 2 : 0, (n % 3 == 0) ? 2 : 0,
                                             1'b0, 1'b0);
      end_checks("runC");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
